ps2_keyboard_receiver: RTL

Parametrised PS/2 keyboard receiver that oversamples the keyboard's `ps2_clk`/`data` lines on the system clock. It checks framing, parity and timeout, and decodes the E0 (extended) and F0 (break) prefixes into tagged key events. Events are buffered in a ready/valid FIFO. It sits between the PS/2 pins and the CPU's memory-mapped keyboard port, replacing the earlier `ps2_clk`-clocked controller. It keeps the `code` output (last make code) for existing consumers.

---
 rtl/ps2_keyboard_receiver.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: oversampled framing/parity/timeout checks, E0/F0 prefix decode,
// and a ready/valid event FIFO with registered head outputs.
module ps2_keyboard_receiver #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          data,
  output logic [7:0]                    code,
  output logic                          event_valid,
  input  logic                          event_ready,
  output logic [7:0]                    event_code,
  output logic                          event_break,
  output logic                          event_ext,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   fall, bit_in;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [7:0]    code_q, code_d;
  logic          perr, ferr, accept, push;
  logic          parity_err_q, frame_err_q, overflow_q;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [9:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [9:0]    head_q, head_d;
  logic          full, do_push, do_pop, ovf;

  // Sync registers reset low so a line that is already idle-high never looks like a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign bit_in = data_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    perr      = 1'b0;
    ferr      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (fall && !bit_in) begin
          state_d   = StData;
          bit_cnt_d = 3'd0;
        end
      end
      StData: begin
        if (fall) begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = bit_in;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StIdle;
          if (!bit_in) ferr = 1'b1;
          else if (!(^{shift_q, par_q})) perr = 1'b1;
          else accept = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // An edge always wins over an expiring counter.
    if (state_q != StIdle) begin
      if (fall) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        ferr    = 1'b1;
        state_d = StIdle;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    code_d = code_q;
    push   = 1'b0;
    if (perr || ferr) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (accept) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!brk_q) code_d = shift_q;
      end
    end
  end

  // A pop in the same cycle frees the slot the write pointer sits on when full.
  always_comb begin
    full     = (count_q == CW'(FIFO_DEPTH));
    do_pop   = (count_q != '0) && event_ready;
    do_push  = push && (!full || do_pop);
    ovf      = push && full && !do_pop;
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = {shift_q, brk_q, ext_q};
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    head_d   = (count_d != '0) ? mem_d[rd_ptr_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      code_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      code_q       <= code_d;
      parity_err_q <= perr;
      frame_err_q  <= ferr;
      overflow_q   <= ovf;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      mem_q        <= mem_d;
    end
  end

  assign code        = code_q;
  assign event_valid = (count_q != '0);
  assign event_code  = head_q[9:2];
  assign event_break = head_q[1];
  assign event_ext   = head_q[0];
  assign fifo_count  = count_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;

endmodule
